// File: rtl/spi_job_sched.sv
// spi_job_sched: job scheduler for the pseudo-SPI output engine.
//
// Descriptors (start address, word count, clock divider) are pushed into a small FIFO and run
// one at a time through the engine. Each job goes IDLE -> LOAD -> RUN -> GAP -> IDLE:
//   LOAD holds BGN low for one cycle with the new descriptor already on the engine inputs,
//   RUN holds BGN high until spi_is_done or the timeout expires, and
//   GAP keeps BGN low for GAP_CYCLES before the next job may be loaded.
// ABORT flushes the queue and, during LOAD/RUN, drops straight into GAP without a pulse.
//
// Ports:
//   CLK, RST_N          clock, asynchronous active-low reset
//   PUSH, PUSH_ADDR,    descriptor enqueue request and payload;
//   PUSH_LEN, PUSH_DIV  accepted when PUSH && PUSH_RDY && !ABORT
//   PUSH_RDY            queue not full (combinational)
//   ABORT               kill current job and flush queue
//   BGN                 engine run (low holds the engine in reset), registered
//   ADDR_BGN, DATA_LEN, descriptor presented to the engine, latched on entry to LOAD
//   FREQ_DIV
//   spi_is_done         engine completion level
//   JOB_DONE            one-cycle pulse, job completed
//   JOB_TIMEOUT         one-cycle pulse, job killed by timeout
//   BUSY                scheduler not idle or queue not empty
//   Q_COUNT             number of queued descriptors
module spi_job_sched #(
   parameter int unsigned MEMORY_ADDR_WIDTH = 9,
   parameter int unsigned RESERVED_DATA_LEN = 8,
   parameter int unsigned QUEUE_DEPTH       = 4,
   parameter int unsigned GAP_CYCLES        = 2,
   parameter int unsigned TIMEOUT_CYCLES    = 4096
) (
   input  logic                             CLK,
   input  logic                             RST_N,
   input  logic                             PUSH,
   input  logic [MEMORY_ADDR_WIDTH-1:0]     PUSH_ADDR,
   input  logic [RESERVED_DATA_LEN-1:0]     PUSH_LEN,
   input  logic [7:0]                       PUSH_DIV,
   output logic                             PUSH_RDY,
   input  logic                             ABORT,
   output logic                             BGN,
   output logic [MEMORY_ADDR_WIDTH-1:0]     ADDR_BGN,
   output logic [RESERVED_DATA_LEN-1:0]     DATA_LEN,
   output logic [7:0]                       FREQ_DIV,
   input  logic                             spi_is_done,
   output logic                             JOB_DONE,
   output logic                             JOB_TIMEOUT,
   output logic                             BUSY,
   output logic [$clog2(QUEUE_DEPTH):0]     Q_COUNT
);

   localparam int unsigned PtrW  = $clog2(QUEUE_DEPTH);
   localparam int unsigned CntW  = PtrW + 1;
   localparam int unsigned DescW = MEMORY_ADDR_WIDTH + RESERVED_DATA_LEN + 8;
   localparam int unsigned GapW  = $clog2(GAP_CYCLES + 1);

   localparam logic [CntW-1:0] Depth   = CntW'(QUEUE_DEPTH);
   localparam logic [CntW-1:0] CntOne  = CntW'(1);
   localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);
   localparam logic [GapW-1:0] GapOne  = GapW'(1);
   localparam logic [GapW-1:0] GapLast = GapW'(GAP_CYCLES - 1);
   localparam logic [15:0]     TmoLast = 16'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {StIdle, StLoad, StRun, StGap} state_e;

   state_e                         state_q, state_d;
   logic [DescW-1:0]               mem_q [QUEUE_DEPTH];
   logic [PtrW-1:0]                wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]                rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]                count_q, count_d;
   logic [MEMORY_ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [RESERVED_DATA_LEN-1:0]   len_q, len_d;
   logic [7:0]                     div_q, div_d;
   logic [15:0]                    tmo_q, tmo_d;
   logic [GapW-1:0]                gap_q, gap_d;
   logic                           bgn_q, bgn_d;
   logic                           done_q, done_d;
   logic                           tmo_ev_q, tmo_ev_d;

   logic push_acc;
   logic pop;

   assign PUSH_RDY = (count_q < Depth);
   // ABORT wins over both queue operations in the same cycle.
   assign push_acc = PUSH && PUSH_RDY && !ABORT;
   assign pop      = (state_q == StIdle) && (count_q != '0) && !ABORT;

   // Job sequencing and descriptor latch.
   always_comb begin
      state_d  = state_q;
      tmo_d    = tmo_q;
      gap_d    = gap_q;
      done_d   = 1'b0;
      tmo_ev_d = 1'b0;
      addr_d   = addr_q;
      len_d    = len_q;
      div_d    = div_q;
      unique case (state_q)
         StIdle: begin
            if (pop) begin
               state_d                 = StLoad;
               {addr_d, len_d, div_d}  = mem_q[rd_ptr_q];
            end
         end
         StLoad: begin
            if (ABORT) begin
               state_d = StGap;
               gap_d   = '0;
            end else begin
               state_d = StRun;
               tmo_d   = '0;
            end
         end
         StRun: begin
            if (ABORT) begin
               state_d = StGap;
               gap_d   = '0;
            end else if (spi_is_done) begin
               done_d  = 1'b1;
               state_d = StGap;
               gap_d   = '0;
            end else if (tmo_q == TmoLast) begin
               tmo_ev_d = 1'b1;
               state_d  = StGap;
               gap_d    = '0;
            end else begin
               tmo_d = tmo_q + 16'd1;
            end
         end
         StGap: begin
            if (gap_q == GapLast) begin
               state_d = StIdle;
            end else begin
               gap_d = gap_q + GapOne;
            end
         end
         default: state_d = StIdle;
      endcase
      // Registered so BGN is high exactly while the state register holds RUN.
      bgn_d = (state_d == StRun);
   end

   // Queue pointers and occupancy.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (ABORT) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_acc) wr_ptr_d = wr_ptr_q + PtrOne;
         if (pop)      rd_ptr_d = rd_ptr_q + PtrOne;
         case ({push_acc, pop})
            2'b10:   count_d = count_q + CntOne;
            2'b01:   count_d = count_q - CntOne;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q  <= StIdle;
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         addr_q   <= '0;
         len_q    <= '0;
         div_q    <= '0;
         tmo_q    <= '0;
         gap_q    <= '0;
         bgn_q    <= 1'b0;
         done_q   <= 1'b0;
         tmo_ev_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         addr_q   <= addr_d;
         len_q    <= len_d;
         div_q    <= div_d;
         tmo_q    <= tmo_d;
         gap_q    <= gap_d;
         bgn_q    <= bgn_d;
         done_q   <= done_d;
         tmo_ev_q <= tmo_ev_d;
         if (push_acc) mem_q[wr_ptr_q] <= {PUSH_ADDR, PUSH_LEN, PUSH_DIV};
      end
   end

   assign BGN         = bgn_q;
   assign ADDR_BGN    = addr_q;
   assign DATA_LEN    = len_q;
   assign FREQ_DIV    = div_q;
   assign JOB_DONE    = done_q;
   assign JOB_TIMEOUT = tmo_ev_q;
   assign Q_COUNT     = count_q;
   assign BUSY        = (state_q != StIdle) || (count_q != '0);

endmodule

// File: tb/tb_spi_job_sched.sv
// Bench for spi_job_sched: directed scenarios with randomized descriptors and engine latencies,
// checked against a queue-based model of accepted jobs and the job timing rules.
module tb_spi_job_sched;

   localparam int QD  = 4;
   localparam int GAP = 2;
   localparam int TMO = 64;

   typedef struct {
      logic [8:0] addr;
      logic [7:0] len;
      logic [7:0] div;
      int         lat;   // engine done latency in BGN-high cycles, 0 = never
   } job_t;

   logic       CLK = 1'b0;
   logic       RST_N = 1'b0;
   logic       PUSH = 1'b0;
   logic [8:0] PUSH_ADDR = '0;
   logic [7:0] PUSH_LEN = '0;
   logic [7:0] PUSH_DIV = '0;
   logic       PUSH_RDY;
   logic       ABORT = 1'b0;
   logic       BGN;
   logic [8:0] ADDR_BGN;
   logic [7:0] DATA_LEN;
   logic [7:0] FREQ_DIV;
   logic       spi_is_done = 1'b0;
   logic       JOB_DONE;
   logic       JOB_TIMEOUT;
   logic       BUSY;
   logic [2:0] Q_COUNT;

   int total = 0;
   int bad = 0;

   job_t mq[$];
   int   eng_lat = 0;
   int   eng_cnt = 0;
   int   lo_len = 0;
   int   last_hi = 0;
   int   last_lo = 0;

   spi_job_sched #(
      .MEMORY_ADDR_WIDTH (9),
      .RESERVED_DATA_LEN (8),
      .QUEUE_DEPTH       (QD),
      .GAP_CYCLES        (GAP),
      .TIMEOUT_CYCLES    (TMO)
   ) dut (
      .CLK         (CLK),
      .RST_N       (RST_N),
      .PUSH        (PUSH),
      .PUSH_ADDR   (PUSH_ADDR),
      .PUSH_LEN    (PUSH_LEN),
      .PUSH_DIV    (PUSH_DIV),
      .PUSH_RDY    (PUSH_RDY),
      .ABORT       (ABORT),
      .BGN         (BGN),
      .ADDR_BGN    (ADDR_BGN),
      .DATA_LEN    (DATA_LEN),
      .FREQ_DIV    (FREQ_DIV),
      .spi_is_done (spi_is_done),
      .JOB_DONE    (JOB_DONE),
      .JOB_TIMEOUT (JOB_TIMEOUT),
      .BUSY        (BUSY),
      .Q_COUNT     (Q_COUNT)
   );

   always #5 CLK = ~CLK;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock, then act as the engine: count BGN-high cycles and raise done at latency.
   task automatic tick();
      @(posedge CLK);
      #1;
      if (BGN) begin
         if (lo_len != 0) last_lo = lo_len;
         lo_len = 0;
         eng_cnt++;
      end else begin
         if (eng_cnt != 0) last_hi = eng_cnt;
         eng_cnt = 0;
         lo_len++;
      end
      spi_is_done = (eng_lat != 0) && BGN && (eng_cnt >= eng_lat);
      chk("pulse_excl", 32'(JOB_DONE & JOB_TIMEOUT), 0);
   endtask

   task automatic wait_level(input logic lvl, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         tick();
         if (BGN === lvl) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   function automatic job_t rand_job(input int lat);
      job_t j;
      j.addr = 9'($urandom);
      j.len  = 8'($urandom);
      j.div  = 8'($urandom);
      j.lat  = lat;
      return j;
   endfunction

   task automatic drive_job(input job_t j);
      PUSH_ADDR = j.addr;
      PUSH_LEN  = j.len;
      PUSH_DIV  = j.div;
   endtask

   task automatic push_job(input job_t j);
      drive_job(j);
      PUSH = 1'b1;
      tick();
      PUSH = 1'b0;
   endtask

   // Follow every job in the model queue to completion; first_up means the head is already running.
   task automatic run_jobs(input bit first_up);
      job_t e;
      bit   ok;
      bit   exp_done;
      int   exp_len;
      int   j = 0;
      while (mq.size() != 0) begin
         e = mq.pop_front();
         if (!(j == 0 && first_up)) begin
            eng_lat = e.lat;
            wait_level(1'b1, ok);
            chk("job_start", 32'(ok), 1);
            if (j != 0) chk("gap_len", last_lo, GAP + 2);
         end
         chk("addr", 32'(ADDR_BGN), 32'(e.addr));
         chk("len", 32'(DATA_LEN), 32'(e.len));
         chk("div", 32'(FREQ_DIV), 32'(e.div));
         exp_done = (e.lat != 0) && (e.lat <= TMO);
         exp_len  = exp_done ? e.lat : TMO;
         wait_level(1'b0, ok);
         chk("job_end", 32'(ok), 1);
         chk("run_len", last_hi, exp_len);
         chk("job_done", 32'(JOB_DONE), 32'(exp_done));
         chk("job_timeout", 32'(JOB_TIMEOUT), 32'(!exp_done));
         tick();
         chk("pulse_clear", 32'({JOB_DONE, JOB_TIMEOUT}), 0);
         j++;
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_bgn"}, 32'(BGN), 0);
      chk({tag, "_addr"}, 32'(ADDR_BGN), 0);
      chk({tag, "_len"}, 32'(DATA_LEN), 0);
      chk({tag, "_div"}, 32'(FREQ_DIV), 0);
      chk({tag, "_done"}, 32'(JOB_DONE), 0);
      chk({tag, "_tmo"}, 32'(JOB_TIMEOUT), 0);
      chk({tag, "_qcount"}, 32'(Q_COUNT), 0);
      chk({tag, "_busy"}, 32'(BUSY), 0);
      chk({tag, "_rdy"}, 32'(PUSH_RDY), 1);
   endtask

   initial begin
      job_t j;
      int   mcnt;
      bit   rdy;
      bit   ok;

      // Reset values.
      #3;
      chk_reset_vals("rst");
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      RST_N = 1'b1;
      tick();

      // Single job, done 40 cycles after BGN rises.
      eng_lat = 40;
      j.addr = 9'h1F0; j.len = 8'd3; j.div = 8'd5; j.lat = 40;
      push_job(j);
      chk("s1_qcount_push", 32'(Q_COUNT), 1);
      chk("s1_busy", 32'(BUSY), 1);
      tick();
      chk("s1_qcount_pop", 32'(Q_COUNT), 0);
      chk("s1_bgn_load", 32'(BGN), 0);
      chk("s1_addr", 32'(ADDR_BGN), 32'h1F0);
      chk("s1_len", 32'(DATA_LEN), 3);
      chk("s1_div", 32'(FREQ_DIV), 5);
      tick();
      chk("s1_bgn_run", 32'(BGN), 1);
      wait_level(1'b0, ok);
      chk("s1_end", 32'(ok), 1);
      chk("s1_run_len", last_hi, 40);
      chk("s1_done", 32'(JOB_DONE), 1);
      chk("s1_tmo", 32'(JOB_TIMEOUT), 0);
      tick();
      chk("s1_done_clear", 32'(JOB_DONE), 0);
      chk("s1_busy_gap", 32'(BUSY), 1);
      tick();
      chk("s1_idle", 32'(BUSY), 0);

      // Five back-to-back pushes into an idle scheduler; the head pops on the second edge.
      mcnt = 0;
      for (int i = 0; i < 5; i++) begin
         j = rand_job($urandom_range(5, 40));
         if (i == 0) eng_lat = j.lat;
         rdy = (mcnt < QD);
         chk("s2_rdy", 32'(PUSH_RDY), 32'(rdy));
         drive_job(j);
         PUSH = 1'b1;
         tick();
         if (rdy) begin
            mq.push_back(j);
            mcnt++;
         end
         if (i == 1) mcnt--;
         chk("s2_qcount", 32'(Q_COUNT), mcnt);
      end
      PUSH = 1'b0;
      run_jobs(1'b1);
      tick();
      chk("s2_idle", 32'(BUSY), 0);

      // Engine never finishes: timeout, then a full queue with the fifth push dropped.
      eng_lat = 0;
      j = rand_job(0);
      push_job(j);
      mq.push_back(j);
      tick();
      tick();
      chk("s3_bgn", 32'(BGN), 1);
      mcnt = 0;
      for (int i = 0; i < 5; i++) begin
         // Latency 64 lands done on the timeout cycle; 65 is just too late.
         j = rand_job(i == 0 ? TMO : (i == 1 ? TMO + 1 : int'($urandom_range(3, 30))));
         rdy = (mcnt < QD);
         chk("s3_rdy", 32'(PUSH_RDY), 32'(rdy));
         drive_job(j);
         PUSH = 1'b1;
         tick();
         if (rdy) begin
            mq.push_back(j);
            mcnt++;
         end
         chk("s3_qcount", 32'(Q_COUNT), mcnt);
      end
      PUSH = 1'b0;
      chk("s3_full", 32'(PUSH_RDY), 0);
      run_jobs(1'b1);
      tick();
      chk("s3_idle", 32'(BUSY), 0);

      // ABORT during RUN with two jobs queued; a same-cycle push is dropped.
      eng_lat = 0;
      PUSH = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive_job(rand_job(0));
         tick();
      end
      PUSH = 1'b0;
      repeat ($urandom_range(1, 10)) tick();
      chk("s4_bgn", 32'(BGN), 1);
      chk("s4_qcount", 32'(Q_COUNT), 2);
      ABORT = 1'b1;
      PUSH = 1'b1;
      tick();
      ABORT = 1'b0;
      PUSH = 1'b0;
      chk("s4_bgn_abort", 32'(BGN), 0);
      chk("s4_no_pulse", 32'({JOB_DONE, JOB_TIMEOUT}), 0);
      chk("s4_flushed", 32'(Q_COUNT), 0);
      tick();
      chk("s4_busy_gap", 32'(BUSY), 1);
      tick();
      chk("s4_idle", 32'(BUSY), 0);
      repeat (20) tick();
      chk("s4_stay_bgn", 32'(BGN), 0);
      chk("s4_stay_busy", 32'(BUSY), 0);
      chk("s4_stay_q", 32'(Q_COUNT), 0);

      // ABORT in the same cycle as done: neither pulse.
      eng_lat = 10;
      push_job(rand_job(10));
      wait_level(1'b1, ok);
      chk("s5_start", 32'(ok), 1);
      repeat (9) tick();
      ABORT = 1'b1;
      tick();
      ABORT = 1'b0;
      chk("s5_bgn", 32'(BGN), 0);
      chk("s5_no_pulse", 32'({JOB_DONE, JOB_TIMEOUT}), 0);
      tick();
      chk("s5_no_late_pulse", 32'({JOB_DONE, JOB_TIMEOUT}), 0);
      tick();
      chk("s5_idle", 32'(BUSY), 0);

      // Reset asserted mid-RUN clears outputs immediately; a new job then runs normally.
      eng_lat = 0;
      PUSH = 1'b1;
      for (int i = 0; i < 2; i++) begin
         drive_job(rand_job(0));
         tick();
      end
      PUSH = 1'b0;
      repeat (3) tick();
      chk("s6_bgn", 32'(BGN), 1);
      chk("s6_qcount", 32'(Q_COUNT), 1);
      #2;
      RST_N = 1'b0;
      #1;
      chk_reset_vals("s6_rst");
      @(negedge CLK);
      RST_N = 1'b1;
      tick();
      j = rand_job($urandom_range(5, 30));
      eng_lat = j.lat;
      push_job(j);
      mq.push_back(j);
      run_jobs(1'b0);
      tick();
      chk("s6_idle", 32'(BUSY), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/spi_job_sched.md
# spi_job_sched

Job scheduler for the pseudo-SPI output engine. Software, or the CPU I/O path, pushes transfer descriptors into a small FIFO. Each descriptor is a start address, a data length and a clock divider. The scheduler runs one descriptor at a time through the engine: it drives BGN, waits for `spi_is_done`, enforces a timeout, then inserts an inter-job gap. It sits between the CPU I/O register block and the SPI engine.

## Interface
- `MEMORY_ADDR_WIDTH`, 9, SRAM address width (matches engine).
- `RESERVED_DATA_LEN`, 8, data-length field width (matches engine).
- `QUEUE_DEPTH`, 4, descriptor FIFO depth; power of two, ≥2.
- `GAP_CYCLES`, 2, cycles BGN is held low between jobs; ≥1.
- `TIMEOUT_CYCLES`, 4096, max RUN cycles per job; 16-bit counter.

Ports:
- `CLK`  in  1  single clock, all flops posedge.
- `RST_N`  in  1  asynchronous, active-low reset.
- `PUSH`  in  1  enqueue request.
- `PUSH_ADDR`  in  MEMORY_ADDR_WIDTH  descriptor start address.
- `PUSH_LEN`  in  RESERVED_DATA_LEN  descriptor word count.
- `PUSH_DIV`  in  8  descriptor frequency divider.
- `PUSH_RDY`  out  1  queue not full; combinational, `count < QUEUE_DEPTH`.
- `ABORT`  in  1  kill current job and flush queue.
- `BGN`  out  1  engine run/reset (low = engine held reset).
- `ADDR_BGN`  out  MEMORY_ADDR_WIDTH  to engine.
- `DATA_LEN`  out  RESERVED_DATA_LEN  to engine.
- `FREQ_DIV`  out  8  to engine.
- `spi_is_done`  in  1  engine completion level.
- `JOB_DONE`  out  1  one-cycle pulse, job completed.
- `JOB_TIMEOUT`  out  1  one-cycle pulse, job killed by timeout.
- `BUSY`  out  1  state ≠ IDLE or count ≠ 0.
- `Q_COUNT`  out  log2(QUEUE_DEPTH)+1  queued descriptors.

## Operation
- **Reset values:**
  - All registered outputs are 0: BGN, ADDR_BGN, DATA_LEN, FREQ_DIV, JOB_DONE, JOB_TIMEOUT and Q_COUNT.
  - BUSY is 0 and PUSH_RDY is 1.
  - Queue is empty, pointers are 0, state is IDLE.
- **FIFO:**
  - A push is accepted on a posedge with `PUSH && PUSH_RDY`.
  - A push while full is silently dropped.
  - A pop happens only on entry to LOAD.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Pointers wrap modulo QUEUE_DEPTH.
- **States:**
  - IDLE: if `count≠0`, go to LOAD next edge and latch the head descriptor into ADDR_BGN/DATA_LEN/FREQ_DIV (pop).
  - LOAD: BGN=0 for exactly one cycle so the engine resets with the new inputs stable, then go to RUN.
  - RUN: BGN=1. The timeout counter starts at 0 on entry and increments each cycle.
    - `spi_is_done` sampled 1 → JOB_DONE pulse, go to GAP.
    - Counter reaches TIMEOUT_CYCLES−1 with no done → JOB_TIMEOUT pulse, go to GAP.
  - GAP: BGN=0 for GAP_CYCLES cycles, then go to IDLE.
- **BGN:** registered, equals 1 exactly in RUN.
- **Descriptor outputs:** hold their last values outside LOAD, so they stay stable through RUN and GAP.
- **ABORT (any state):**
  - Queue is flushed (count=0, pointers=0).
  - In LOAD or RUN, go to GAP with no JOB_DONE/JOB_TIMEOUT pulse.
  - In IDLE or GAP, the state is otherwise unaffected.
- **Priority, highest first:** ABORT > done > timeout. A push in the same cycle as ABORT is dropped.
- **Reset mid-job:** BGN drops asynchronously to 0 and the engine is reset with it; queue contents are lost.

## Timing
- Push into an empty idle scheduler captured at edge k:
  - Q_COUNT=1 after k.
  - LOAD and pop at k+1 (Q_COUNT=0).
  - BGN rises at k+2.
- `spi_is_done` high sampled at edge d:
  - BGN=0 and JOB_DONE=1 after d.
  - JOB_DONE=0 after d+1.
- Back-to-back jobs: BGN low gap = GAP_CYCLES + 2 cycles (GAP, then IDLE, then LOAD).
- Timeout: BGN is high for exactly TIMEOUT_CYCLES cycles, then JOB_TIMEOUT pulses.
- JOB_DONE and JOB_TIMEOUT are never high together.

## Test plan
- Reset, then push one job (ADDR=0x1F0, LEN=3, DIV=5) with an engine model that asserts done 40 cycles after BGN↑.
  - Outputs show 0x1F0/3/5 one cycle before BGN↑.
  - BGN high for 40 cycles, then one JOB_DONE pulse.
  - BUSY=0 after GAP+IDLE.
- Push 5 jobs back-to-back with QUEUE_DEPTH=4 while IDLE.
  - PUSH_RDY drops once Q_COUNT reaches 4; at most one push is lost, per the count at the time.
  - Accepted jobs run in FIFO order, each separated by BGN low for 4 cycles.
- Engine never asserts done, TIMEOUT_CYCLES=64.
  - BGN high exactly 64 cycles, then JOB_TIMEOUT pulse, no JOB_DONE.
  - The next queued job then starts.
- ABORT during RUN with 2 jobs queued.
  - BGN=0 next cycle, no pulse, Q_COUNT=0.
  - Scheduler reaches IDLE after the gap and stays there.
- `spi_is_done` rises in the same cycle the timeout expires → JOB_DONE only. Separately, ABORT in the same cycle as done → neither pulse.
- Assert RST_N low mid-RUN → BGN, Q_COUNT and the descriptor outputs go to 0 immediately. After release, a new push runs normally.
